// File: rtl/if_fetch.sv
// Instruction fetch stage: PC, in-order imem reads, prefetch FIFO, redirect and halt.
// Optional IF_HALT_PREDECODE_EN: halt on popping a [31:30]=11, [28]=1 word.
module if_fetch #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [31:0]   NOP_WORD = 32'hC800_0000
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_rvalid,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          halt_in,
  input  logic          id_ready,
  output logic [31:0]   instruction,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  output logic          halted
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] pc;
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] fifo_pc   [DEPTH];
  logic [AW-1:0] tag_q     [DEPTH];
  logic [PW-1:0] f_rd, f_wr, t_rd, t_wr;
  logic [CW-1:0] occ, outstanding, drop_cnt;
  logic [CW:0]   in_use;
  logic [31:0]   head_word;
  logic          redirect, pop, push, pre_halt;

  assign redirect    = br_taken & ~halted;
  assign head_word   = fifo_data[f_rd];
  assign instr_valid = (occ != '0) & ~halted;
  assign pop         = instr_valid & id_ready & ~redirect;
  assign push        = imem_rvalid & (drop_cnt == '0) & ~redirect & ~halted;

  // A slot popped this cycle is already free, which is what sustains 1 instr/cycle at DEPTH=2.
  assign in_use   = {1'b0, occ} + {1'b0, outstanding} - (CW+1)'(pop);
  assign imem_req = ~rst & ~halted & ~br_taken & (in_use < (CW+1)'(DEPTH));
  assign imem_addr = pc;

  assign instruction = instr_valid ? head_word      : NOP_WORD;
  assign instr_pc    = instr_valid ? fifo_pc[f_rd]  : '0;

`ifdef IF_HALT_PREDECODE_EN
  assign pre_halt = pop & (head_word[31:30] == 2'b11) & head_word[28];
`else
  assign pre_halt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      f_rd        <= '0;
      f_wr        <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
      occ         <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      halted      <= 1'b0;
    end else begin
      if (halt_in || pre_halt) halted <= 1'b1;
      outstanding <= outstanding + CW'(imem_req) - CW'(imem_rvalid);
      if (redirect) begin
        pc       <= br_target;
        f_rd     <= '0;
        f_wr     <= '0;
        t_rd     <= '0;
        t_wr     <= '0;
        occ      <= '0;
        drop_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (imem_req) begin
          pc   <= pc + 1'b1;
          t_wr <= t_wr + 1'b1;
        end
        if (push) begin
          f_wr <= f_wr + 1'b1;
          t_rd <= t_rd + 1'b1;
        end
        if (pop) f_rd <= f_rd + 1'b1;
        occ <= occ + CW'(push) - CW'(pop);
        if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) tag_q[t_wr] <= pc;
    if (push) begin
      fifo_data[f_wr] <= imem_rdata;
      fifo_pc[f_wr]   <= tag_q[t_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && occ == CW'(DEPTH)));
  end

endmodule
